// File: rtl/if_stage_hs_if.sv
// rtl/if_stage_hs_if.sv - instruction-memory valid/ready fetch handshake bundle
// Purpose: groups the fetch request/response signals between the IF stage and imem.
// Signals:
//   imem_req    fetch stage -> memory : request is live this cycle
//   imem_addr   fetch stage -> memory : fetch address, held while waiting
//   imem_ready  memory -> fetch stage : request accepted, data valid this cycle
//   imem_rdata  memory -> fetch stage : fetched instruction word
interface if_stage_hs_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [XLEN-1:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage_hs.sv
// rtl/if_stage_hs.sv - instruction fetch stage with valid/ready imem handshake and skid register
// Purpose: drives the PC and imem fetch, fills the IF/ID register, absorbs one
// instruction in a skid register when ID stalls, and handles redirect/flush.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   pcsrc, branch_target  redirect pulse and its target address
//   stall, flush          ID back-pressure, IF/ID kill
//   imem                  fetch handshake (master side)
//   pc_out                current PC (same as imem_addr)
//   if_id_ir/npc/valid    IF/ID pipeline register
module if_stage_hs #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INC      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcsrc,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  input  logic               flush,
  if_stage_hs_if.master      imem,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [XLEN-1:0]    if_id_ir,
  output logic [ADDR_W-1:0]  if_id_npc,
  output logic               if_id_valid
);

  localparam logic [ADDR_W-1:0] INC_A = ADDR_W'(INC);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   skid_ir_q, skid_ir_d;
  logic [ADDR_W-1:0] skid_npc_q, skid_npc_d;
  logic [ADDR_W-1:0] redir_q, redir_d;

  logic              req;
  logic              accept;
  logic              load_ok;
  logic [ADDR_W-1:0] npc;

  // DISCARD keeps requesting so the outstanding transfer can complete and be dropped.
  assign req     = ~reset & ((state_q == S_FETCH) | (state_q == S_DISCARD));
  assign accept  = req & imem.imem_ready;
  assign load_ok = ~stall | ~valid_q;
  assign npc     = pc_q + INC_A;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign pc_out         = pc_q;
  assign if_id_ir       = ir_q;
  assign if_id_npc      = npc_q;
  assign if_id_valid    = valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      npc_q      <= '0;
      valid_q    <= 1'b0;
      skid_ir_q  <= '0;
      skid_npc_q <= '0;
      redir_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      npc_q      <= npc_d;
      valid_q    <= valid_d;
      skid_ir_q  <= skid_ir_d;
      skid_npc_q <= skid_npc_d;
      redir_q    <= redir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    npc_d      = npc_q;
    valid_d    = valid_q;
    skid_ir_d  = skid_ir_q;
    skid_npc_d = skid_npc_q;
    redir_d    = redir_q;

    case (state_q)
      S_FETCH: begin
        if (pcsrc) begin
          valid_d = 1'b0;
          if (flush) ir_d = '0;
          if (accept) begin
            pc_d = branch_target;
          end else begin
            // Request already on the bus must finish before the new PC can be issued.
            redir_d = branch_target;
            state_d = S_DISCARD;
          end
        end else if (flush) begin
          // pc not advanced, so the killed address is refetched.
          valid_d = 1'b0;
          ir_d    = '0;
        end else if (accept) begin
          pc_d = npc;
          if (load_ok) begin
            ir_d    = imem.imem_rdata;
            npc_d   = npc;
            valid_d = 1'b1;
          end else begin
            skid_ir_d  = imem.imem_rdata;
            skid_npc_d = npc;
            state_d    = S_HOLD;
          end
        end else if (!stall) begin
          // ID consumed its instruction and nothing new arrived: insert a bubble.
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (pcsrc) begin
          valid_d    = 1'b0;
          if (flush) ir_d = '0;
          pc_d       = branch_target;
          skid_ir_d  = '0;
          skid_npc_d = '0;
          state_d    = S_FETCH;
        end else if (flush) begin
          // pc already moved past the skid word; step back so it is fetched again.
          valid_d    = 1'b0;
          ir_d       = '0;
          pc_d       = skid_npc_q - INC_A;
          skid_ir_d  = '0;
          skid_npc_d = '0;
          state_d    = S_FETCH;
        end else if (load_ok) begin
          ir_d       = skid_ir_q;
          npc_d      = skid_npc_q;
          valid_d    = 1'b1;
          skid_ir_d  = '0;
          skid_npc_d = '0;
          state_d    = S_FETCH;
        end
      end

      S_DISCARD: begin
        valid_d = 1'b0;
        if (flush) ir_d = '0;
        if (pcsrc) redir_d = branch_target;
        if (accept) begin
          pc_d    = pcsrc ? branch_target : redir_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage_hs.sv
// tb/tb_if_stage_hs.sv - self-checking bench for if_stage_hs
module tb_if_stage_hs;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] INC    = 32'd4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pcsrc;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_npc;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  if_stage_hs_if #(.XLEN(32), .ADDR_W(32)) imem_bus ();
  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

  if_stage_hs #(.XLEN(32), .ADDR_W(32), .RESET_PC(RST_PC), .INC(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .flush         (flush),
    .imem          (imem_bus),
    .pc_out        (pc_out),
    .if_id_ir      (if_id_ir),
    .if_id_npc     (if_id_npc),
    .if_id_valid   (if_id_valid)
  );

  // Narrow-address instance used for PC wrap-around.
  logic        rst8;
  logic [7:0]  pc_out8;
  logic [31:0] ir8;
  logic [7:0]  npc8;
  logic        valid8;
  if_stage_hs_if #(.XLEN(32), .ADDR_W(8)) bus8 ();
  assign bus8.imem_rdata = mem_word({24'd0, bus8.imem_addr});
  assign bus8.imem_ready = 1'b1;

  if_stage_hs #(.XLEN(32), .ADDR_W(8), .RESET_PC(8'hF4), .INC(4)) dut8 (
    .clk           (clk),
    .reset         (rst8),
    .pcsrc         (1'b0),
    .branch_target (8'h00),
    .stall         (1'b0),
    .flush         (1'b0),
    .imem          (bus8),
    .pc_out        (pc_out8),
    .if_id_ir      (ir8),
    .if_id_npc     (npc8),
    .if_id_valid   (valid8)
  );

  // Reference model: PC, IF/ID contents, a one-deep queue of parked instructions,
  // and an optional pending redirect.
  logic [31:0] m_pc, m_ir, m_npc, m_redir;
  logic        m_valid, m_pend;
  logic [63:0] m_skid[$];

  logic        obs_req, exp_req;
  logic [31:0] obs_addr, exp_addr;

  task automatic model_reset();
    m_pc = RST_PC; m_ir = 0; m_npc = 0; m_valid = 0;
    m_pend = 0; m_redir = 0; m_skid.delete();
  endtask

  task automatic model_step(input logic p, input logic [31:0] t, input logic s,
                            input logic f, input logic r);
    logic acc, ld;
    acc = (m_skid.size() == 0) && r;
    ld  = !s || !m_valid;
    if (p) begin
      m_valid = 0;
      if (f) m_ir = 0;
      if (m_skid.size() != 0) begin
        m_skid.delete(); m_pc = t;
      end else if (acc) begin
        m_pc = t; m_pend = 0;
      end else begin
        m_pend = 1; m_redir = t;
      end
    end else if (f) begin
      m_valid = 0; m_ir = 0;
      if (m_skid.size() != 0) begin
        m_pc = m_skid[0][31:0] - INC; m_skid.delete();
      end else if (m_pend && acc) begin
        m_pc = m_redir; m_pend = 0;
      end
    end else if (m_skid.size() != 0) begin
      if (ld) begin
        m_ir = m_skid[0][63:32]; m_npc = m_skid[0][31:0]; m_valid = 1; m_skid.delete();
      end
    end else if (m_pend) begin
      if (acc) begin m_pc = m_redir; m_pend = 0; end
    end else if (acc) begin
      if (ld) begin
        m_ir = mem_word(m_pc); m_npc = m_pc + INC; m_valid = 1;
      end else begin
        m_skid.push_back({mem_word(m_pc), m_pc + INC});
      end
      m_pc = m_pc + INC;
    end else if (!s) begin
      m_valid = 0;
    end
  endtask

  task automatic drive_cycle(input logic p, input logic [31:0] t, input logic s,
                             input logic f, input logic r);
    @(negedge clk);
    pcsrc = p; branch_target = t; stall = s; flush = f; imem_bus.imem_ready = r;
    #1;
    obs_req  = imem_bus.imem_req;
    obs_addr = imem_bus.imem_addr;
    exp_req  = (m_skid.size() == 0);
    exp_addr = m_pc;
    model_step(p, t, s, f, r);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; rst8 = 1; pcsrc = 0; stall = 0; flush = 0; branch_target = 0;
    imem_bus.imem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_bus.imem_req); end
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_out, RST_PC); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", if_id_valid); end
    checks++; if (if_id_ir !== 32'd0 || if_id_npc !== 32'd0) begin errors++; $display("FAIL reset_ifid ir=%h npc=%h exp=0", if_id_ir, if_id_npc); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0, 0, 1);
      checks++; if (obs_addr !== RST_PC + 4*k) begin errors++; $display("FAIL seq_addr%0d got=%h exp=%h", k, obs_addr, RST_PC + 4*k); end
      checks++; if (if_id_valid !== 1'b1 || if_id_ir !== mem_word(RST_PC + 4*k) || if_id_npc !== RST_PC + 4*k + 4)
        begin errors++; $display("FAIL seq_ifid%0d v=%0b ir=%h npc=%h exp ir=%h npc=%h", k, if_id_valid, if_id_ir, if_id_npc, mem_word(RST_PC + 4*k), RST_PC + 4*k + 4); end
    end
    checks++; if (pc_out !== 32'h10C) begin errors++; $display("FAIL seq_pc got=%h exp=10c", pc_out); end
  endtask

  task automatic test_wait_states();
    drive_cycle(1, 32'h8, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0, 0, (k == 2));
      checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin errors++; $display("FAIL wait_addr%0d req=%0b addr=%h exp=1/8", k, obs_req, obs_addr); end
    end
    checks++; if (if_id_valid !== 1'b1 || if_id_ir !== mem_word(32'h8) || if_id_npc !== 32'hC)
      begin errors++; $display("FAIL wait_ifid v=%0b ir=%h npc=%h exp ir=%h npc=c", if_id_valid, if_id_ir, if_id_npc, mem_word(32'h8)); end
  endtask

  task automatic test_stall_skid();
    drive_cycle(1, 32'hC, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (if_id_valid !== 1'b1 || if_id_ir !== mem_word(32'hC) || if_id_npc !== 32'h10)
      begin errors++; $display("FAIL skid_pre v=%0b ir=%h npc=%h", if_id_valid, if_id_ir, if_id_npc); end
    drive_cycle(0, 0, 1, 0, 1);
    checks++; if (if_id_ir !== mem_word(32'hC) || if_id_npc !== 32'h10 || pc_out !== 32'h14)
      begin errors++; $display("FAIL skid_park ir=%h npc=%h pc=%h exp npc=10 pc=14", if_id_ir, if_id_npc, pc_out); end
    drive_cycle(0, 0, 1, 0, 1);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL skid_hold_req got=%0b exp=0", obs_req); end
    checks++; if (if_id_valid !== 1'b1 || if_id_ir !== mem_word(32'hC)) begin errors++; $display("FAIL skid_hold_ifid v=%0b ir=%h", if_id_valid, if_id_ir); end
    drive_cycle(0, 0, 0, 0, 0);
    checks++; if (if_id_valid !== 1'b1 || if_id_ir !== mem_word(32'h10) || if_id_npc !== 32'h14)
      begin errors++; $display("FAIL skid_release v=%0b ir=%h npc=%h exp ir=%h npc=14", if_id_valid, if_id_ir, if_id_npc, mem_word(32'h10)); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h14) begin errors++; $display("FAIL skid_resume req=%0b addr=%h exp=1/14", obs_req, obs_addr); end
  endtask

  task automatic test_redirect_discard();
    drive_cycle(1, 32'h20, 0, 0, 1);
    drive_cycle(1, 32'h40, 0, 0, 0);
    checks++; if (obs_addr !== 32'h20 || if_id_valid !== 1'b0) begin errors++; $display("FAIL disc_enter addr=%h v=%0b exp=20/0", obs_addr, if_id_valid); end
    drive_cycle(0, 0, 0, 0, 0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h20) begin errors++; $display("FAIL disc_wait req=%0b addr=%h exp=1/20", obs_req, obs_addr); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h40) begin errors++; $display("FAIL disc_drop v=%0b pc=%h exp=0/40", if_id_valid, pc_out); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (obs_addr !== 32'h40 || if_id_valid !== 1'b1 || if_id_ir !== mem_word(32'h40) || if_id_npc !== 32'h44)
      begin errors++; $display("FAIL disc_target addr=%h v=%0b ir=%h npc=%h", obs_addr, if_id_valid, if_id_ir, if_id_npc); end
  endtask

  task automatic test_flush();
    drive_cycle(1, 32'h2C, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 1, 1);
    checks++; if (if_id_valid !== 1'b0 || if_id_ir !== 32'd0 || pc_out !== 32'h30)
      begin errors++; $display("FAIL flush_kill v=%0b ir=%h pc=%h exp=0/0/30", if_id_valid, if_id_ir, pc_out); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++; if (obs_addr !== 32'h30 || if_id_ir !== mem_word(32'h30)) begin errors++; $display("FAIL flush_refetch addr=%h ir=%h exp=30/%h", obs_addr, if_id_ir, mem_word(32'h30)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic p, s, f, r;
      logic [31:0] t;
      p = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) != 0);
      t = $urandom & 32'hFFFF_FFFC;
      drive_cycle(p, t, s, f, r);
      checks++; if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr))
        begin errors++; $display("FAIL rnd_req%0d req=%0b addr=%h exp=%0b/%h", i, obs_req, obs_addr, exp_req, exp_addr); end
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc%0d got=%h exp=%h", i, pc_out, m_pc); end
      checks++; if (if_id_valid !== m_valid || if_id_ir !== m_ir || if_id_npc !== m_npc)
        begin errors++; $display("FAIL rnd_ifid%0d v=%0b ir=%h npc=%h exp %0b %h %h", i, if_id_valid, if_id_ir, if_id_npc, m_valid, m_ir, m_npc); end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(0, 0, 0, 0, 1);
    #2;
    reset = 1;
    #1;
    checks++; if (pc_out !== RST_PC || if_id_valid !== 1'b0 || imem_bus.imem_req !== 1'b0)
      begin errors++; $display("FAIL async_reset pc=%h v=%0b req=%0b exp=%h/0/0", pc_out, if_id_valid, imem_bus.imem_req, RST_PC); end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst8 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_out8 !== 8'hFC) begin errors++; $display("FAIL wrap_pre pc=%h exp=fc", pc_out8); end
    @(posedge clk); #1;
    checks++; if (pc_out8 !== 8'h00 || npc8 !== 8'h00 || valid8 !== 1'b1 || ir8 !== mem_word(32'hFC))
      begin errors++; $display("FAIL wrap pc=%h npc=%h v=%0b ir=%h exp 00/00/1/%h", pc_out8, npc8, valid8, ir8, mem_word(32'hFC)); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_skid();
    test_redirect_discard();
    test_flush();
    test_random();
    test_async_reset();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage_hs.md
Name: if_stage_hs

Overview:
Parametrised instruction-fetch stage with a valid/ready instruction-memory handshake, so memory may take a variable number of wait states. Supports branch redirect to an explicit target, back-pressure stall from ID, and pipeline flush. A skid register preserves an instruction returned while ID is stalled. Sits between the PC/imem and the ID stage and drives the IF/ID pipeline register.

Parameters:
XLEN, 32, instruction width in bits
ADDR_W, 32, PC / fetch address width
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)
INC, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
pcsrc  in  1  redirect request; one-cycle pulse from ID/EX
branch_target  in  ADDR_W  redirect address, sampled when pcsrc=1
stall  in  1  ID cannot accept; hold IF/ID
flush  in  1  kill IF/ID contents and any same-cycle fetched instruction
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= pc_out)
imem_ready  in  1  memory accepts/returns this cycle; data on imem_rdata same cycle
imem_rdata  in  XLEN  fetched instruction
pc_out  out  ADDR_W  current PC
if_id_ir  out  XLEN  IF/ID instruction
if_id_npc  out  ADDR_W  IF/ID next-sequential PC
if_id_valid  out  1  IF/ID holds a live instruction

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC; if_id_ir=0; if_id_npc=0; if_id_valid=0.
  - Skid register empty; state=FETCH.
  - imem_req=0 while reset is high.
- Definitions:
  - accept = imem_req & imem_ready.
  - npc = pc+INC, modulo 2^ADDR_W; wraps silently.
  - load_ok = ~stall | ~if_id_valid.
- Handshake:
  - imem_req=1 only in FETCH and DISCARD.
  - imem_addr stays stable while imem_req=1 and imem_ready=0. pc never changes while a request is outstanding, except on DISCARD completion.
  - Zero-wait memory (ready tied high) gives one instruction per cycle. Latency from pc to if_id_ir is one edge after accept.
- States:
  - FETCH, accept, flush=0, pcsrc=0, load_ok=1: IF/ID <= {imem_rdata, npc, valid=1}; pc <= npc; stay in FETCH.
  - FETCH, accept, flush=0, pcsrc=0, load_ok=0: skid <= {imem_rdata, npc}; pc <= npc; go to HOLD. IF/ID is unchanged.
  - FETCH, no accept, pcsrc=1, imem_req outstanding: redir <= branch_target; go to DISCARD; IF/ID valid <= 0.
  - HOLD: imem_req=0. When load_ok=1, IF/ID <= skid with valid=1, skid cleared, go to FETCH.
  - DISCARD: keep requesting the old address. On accept, drop the data, pc <= redir, go to FETCH.
- Redirect (pcsrc=1), priority over stall:
  - In FETCH with accept in the same cycle: data discarded; pc <= branch_target; if_id_valid <= 0; stay in FETCH.
  - In HOLD: skid dropped; pc <= branch_target; if_id_valid <= 0; go to FETCH.
  - In DISCARD: redir overwritten with the newest branch_target.
- Flush without pcsrc:
  - if_id_valid <= 0 and if_id_ir <= 0 (NOP).
  - Same-cycle accepted data is discarded and pc is not advanced, so the same address is refetched.
  - In HOLD: skid dropped and pc rewound to skid npc-INC, so the skid instruction is refetched; go to FETCH.
- Stall:
  - If if_id_valid=1, IF/ID holds all fields.
  - If if_id_valid=0, the bubble may be filled regardless of stall.
- Simultaneous events:
  - reset beats everything; pcsrc beats flush; flush beats stall.
  - flush together with pcsrc behaves as pcsrc, with if_id_ir also zeroed.
- branch_target is used unmodified; no alignment check.

Test Plan:
- Reset with RESET_PC=0x100, ready=1 -> pc_out=0x100, if_id_valid=0. After 3 cycles, IF/ID holds the instruction at 0x108 with npc=0x10C, one per cycle.
- ready low for 2 cycles at pc=0x8 -> imem_addr held at 0x8 for 3 cycles. The instruction lands in IF/ID one edge after ready, with npc=0xC.
- stall=1 with IF/ID valid, accept at 0x10 -> state HOLD, imem_req=0, IF/ID unchanged. Release stall -> IF/ID gets the 0x10 instruction with npc=0x14, then fetch resumes at 0x14.
- pcsrc=1, target=0x40, while the 0x20 request waits (ready=0) -> DISCARD. When ready rises, the data is dropped, next request addr=0x40, and if_id_valid stays 0 until the 0x40 fetch.
- flush=1 alone at pc=0x30 with accept -> if_id_valid=0, if_id_ir=0, next cycle imem_addr=0x30 again.
- ADDR_W=8, INC=4, pc=0xFC, accept -> pc wraps to 0x00, if_id_npc=0x00.
